// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer for the data-side SRAM-like bus
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  MemReadTypeM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        stage_en,
  input  logic        flushM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_mem,
  output logic [31:0] load_dataM,
  output logic        AdEL,
  output logic        AdES
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic        sign_q;
  logic        kill_q;
  logic        acc;
  logic        misaligned;
  logic        issue;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        kill_now;

  assign acc        = (MemReadM | MemWriteM) & (MemReadTypeM != 3'b111) & ~flushM;
  assign misaligned = ((MemReadTypeM[1:0] == 2'b10) & (addrM[1:0] != 2'b00)) |
                      ((MemReadTypeM[1:0] == 2'b01) & addrM[0]);
  assign issue      = acc & ~misaligned;
  assign AdEL       = acc & misaligned & ~MemWriteM;
  assign AdES       = acc & misaligned & MemWriteM;
  assign stall_mem  = ((state == IDLE) & issue) | (state == REQ) | (state == WAIT);
  // A flush seen at any point of the transaction discards its result.
  assign kill_now   = kill_q | flushM;

  always_comb begin
    wdata_rep = wdataM;
    case (MemReadTypeM[1:0])
      2'b00:   wdata_rep = {4{wdataM[7:0]}};
      2'b01:   wdata_rep = {2{wdataM[15:0]}};
      default: wdata_rep = wdataM;
    endcase
  end

  assign shifted = data_rdata >> {data_addr[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (data_size)
      2'b00:   load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      load_dataM <= 32'h0;
      sign_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= MemWriteM;
            data_size  <= MemReadTypeM[1:0];
            data_addr  <= addrM;
            data_wdata <= wdata_rep;
            sign_q     <= MemReadTypeM[2];
            kill_q     <= 1'b0;
          end
        end
        REQ: begin
          if (flushM) kill_q <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              state <= kill_now ? IDLE : DONE;
              if (!kill_now && !data_wr) load_dataM <= load_ext;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flushM) kill_q <= 1'b1;
          if (data_data_ok) begin
            state <= kill_now ? IDLE : DONE;
            if (!kill_now && !data_wr) load_dataM <= load_ext;
          end
        end
        default: begin
          // Hold here until the pipeline moves on, so the same op is not reissued.
          if (stage_en || flushM) state <= IDLE;
        end
      endcase
    end
  end

endmodule
